// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame shape and a 2-of-3 vote helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic [2:0] s_IDLE         = 3'b000;
    localparam logic [2:0] s_RX_START_BIT = 3'b001;
    localparam logic [2:0] s_RX_DATA_BITS = 3'b010;
    localparam logic [2:0] s_RX_STOP_BIT  = 3'b011;
    localparam logic [2:0] s_CLEANUP      = 3'b100;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop falling-edge synchroniser for the asynchronous serial line.
// Reset forces both stages to the idle-high level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, one-cycle DV / framing-error strobes; falling-edge clocked.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point (decision one cycle later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085,
    parameter int N            = 11
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_DV,
    output logic       o_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [N-1:0] BIT_TERM = N'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [N-1:0] START_TERM = N'((CLKS_PER_BIT - 1) / 2 + 1);
`else
    localparam logic [N-1:0] START_TERM = N'((CLKS_PER_BIT - 1) / 2);
`endif

    logic       rx_s;
    logic       sample;
    logic [2:0] state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       ferr_q, ferr_d;
    logic       active_q, active_d;
    logic       armed_q, armed_d;

    uart_rx_sync u_sync (
        .clk_i (i_Clock),
        .rst_i (rst),
        .d_i   (i_Rx_Serial),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[1] is rx_s two cycles back, hist_q[0] one cycle back.
    logic [1:0] hist_q;

    always_ff @(negedge i_Clock) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = dv_q;
        ferr_d   = ferr_q;
        active_d = active_q;
        armed_d  = armed_q | rx_s;

        case (state_q)
            s_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s && armed_q) begin
                    state_d = s_RX_START_BIT;
                end
            end
            s_RX_START_BIT: begin
                if (cnt_q == START_TERM) begin
                    cnt_d = '0;
                    if (!sample) begin
                        active_d = 1'b1;
                        state_d  = s_RX_DATA_BITS;
                    end else begin
                        state_d  = s_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            s_RX_DATA_BITS: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sample;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = s_RX_STOP_BIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            s_RX_STOP_BIT: begin
                if (cnt_q == BIT_TERM) begin
                    cnt_d = '0;
                    if (sample) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        // Disarm so a held-low break cannot look like a new start bit.
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                    state_d = s_CLEANUP;
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
            s_CLEANUP: begin
                dv_d     = 1'b0;
                ferr_d   = 1'b0;
                active_d = 1'b0;
                state_d  = s_IDLE;
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(negedge i_Clock) begin
        if (rst) begin
            state_q  <= s_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
            armed_q  <= armed_d;
        end
    end

    assign o_Rx_Byte   = byte_q;
    assign o_Rx_DV     = dv_q;
    assign o_Frame_Err = ferr_q;
    assign o_Rx_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks/bit; outputs sampled on the rising edge, away from the active falling edge.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx_line;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       frame_err;
    logic       rx_active;

    int errors = 0;
    int checks = 0;

    int         dv_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         start_cnt = 0;
    logic       active_prev = 1'b0;
    logic [7:0] dv_bytes[$];

    logic [7:0] glitch_exp;
    int         starts_before;

    uart_rx #(
        .CLKS_PER_BIT (8),
        .N            (4)
    ) dut (
        .i_Clock     (clk),
        .rst         (rst),
        .i_Rx_Serial (rx_line),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_DV     (rx_dv),
        .o_Frame_Err (frame_err),
        .o_Rx_Active (rx_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event monitor: counts strobes and activity starts seen on the rising edge.
    always @(posedge clk) begin
        if (rx_dv) begin
            dv_cnt++;
            dv_bytes.push_back(rx_byte);
        end
        if (frame_err) ferr_cnt++;
        if (rx_dv && frame_err) both_cnt++;
        if (rx_active && !active_prev) start_cnt++;
        active_prev = rx_active;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            rx_line = 1'b1;
        end
    endtask

    // Drives the first nslots of a 10-bit frame, 8 slots per bit; optional 1-slot
    // inversion at the centre slot of each data bit.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input bit glitch, input int nslots);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int s = 0; s < 8; s++) begin
                if (j * 8 + s < nslots) begin
                    @(posedge clk);
                    if (glitch && j >= 1 && j <= 8 && s == 4) rx_line = ~bits[j];
                    else rx_line = bits[j];
                end
            end
        end
    endtask

    initial begin
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h96;
`else
        glitch_exp = 8'h69;
`endif
        rst = 1'b1;
        rx_line = 1'b1;
        repeat (4) @(posedge clk);
        chk("reset_byte", {24'd0, rx_byte}, 32'h00);
        chk("reset_dv", {31'd0, rx_dv}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_active", {31'd0, rx_active}, 32'd0);
        rst = 1'b0;
        idle(10);

        // Single frame 0xA5
        drive_frame(8'hA5, 1'b1, 1'b0, 80);
        idle(20);
        chk("a5_dv_count", dv_cnt, 1);
        chk("a5_byte", {24'd0, rx_byte}, 32'hA5);
        chk("a5_dv_byte", {24'd0, dv_bytes[0]}, 32'hA5);
        chk("a5_no_ferr", ferr_cnt, 0);

        // Back-to-back 0x00 then 0xFF
        drive_frame(8'h00, 1'b1, 1'b0, 80);
        drive_frame(8'hFF, 1'b1, 1'b0, 80);
        idle(20);
        chk("b2b_dv_count", dv_cnt, 3);
        chk("b2b_first", {24'd0, dv_bytes[1]}, 32'h00);
        chk("b2b_second", {24'd0, dv_bytes[2]}, 32'hFF);

        // 2-cycle low glitch on idle line
        starts_before = start_cnt;
        @(posedge clk); rx_line = 1'b0;
        @(posedge clk); rx_line = 1'b0;
        idle(30);
        chk("glitch_no_dv", dv_cnt, 3);
        chk("glitch_no_ferr", ferr_cnt, 0);
        chk("glitch_no_active", start_cnt, starts_before);
        chk("glitch_state_idle", {29'd0, dut.state_q}, 32'd0);

        // 0x96 with centre-slot glitches on every data bit
        drive_frame(8'h96, 1'b1, 1'b1, 80);
        idle(20);
        chk("centre_glitch_dv", dv_cnt, 4);
        chk("centre_glitch_byte", {24'd0, rx_byte}, {24'd0, glitch_exp});

        // 0x3C with low stop bit, then line held low
        starts_before = start_cnt;
        drive_frame(8'h3C, 1'b0, 1'b0, 80);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            rx_line = 1'b0;
        end
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_no_dv", dv_cnt, 4);
        chk("ferr_byte_kept", {24'd0, rx_byte}, {24'd0, glitch_exp});
        chk("break_no_retrigger", start_cnt, starts_before + 1);
        chk("break_active_low", {31'd0, rx_active}, 32'd0);
        idle(20);
        drive_frame(8'h3C, 1'b1, 1'b0, 80);
        idle(20);
        chk("after_break_dv", dv_cnt, 5);
        chk("after_break_byte", {24'd0, rx_byte}, 32'h3C);

        // Reset pulsed during data bit 4 of 0x5A
        drive_frame(8'h5A, 1'b1, 1'b0, 8 * 5 + 3);
        chk("mid_frame_active", {31'd0, rx_active}, 32'd1);
        rst = 1'b1;
        rx_line = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        chk("rst_mid_byte", {24'd0, rx_byte}, 32'h00);
        chk("rst_mid_dv", {31'd0, rx_dv}, 32'd0);
        chk("rst_mid_active", {31'd0, rx_active}, 32'd0);
        chk("rst_mid_state", {29'd0, dut.state_q}, 32'd0);
        idle(100);
        chk("rst_no_dv", dv_cnt, 5);
        chk("rst_no_ferr", ferr_cnt, 1);
        drive_frame(8'h81, 1'b1, 1'b0, 80);
        idle(20);
        chk("post_rst_dv", dv_cnt, 6);
        chk("post_rst_byte", {24'd0, rx_byte}, 32'h81);

        chk("dv_ferr_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
